mux_1_2_hls_deadlock_axis_stall_detector: RTL and testbench
===========================================================

MUX_1_2_HLS_DEADLOCK_AXIS_STALL_DETECTOR -- requirements
Module: mux_1_2_hls_deadlock_axis_stall_detector

Interface
REQ-001 Parameter NUM_CH, default 3: number of monitored AXI-Stream channels.
REQ-002 Parameter CNT_W, default 16: stall counter width.
REQ-003 Parameter STALL_THRESHOLD, default 16: consecutive stalled cycles before block is flagged; legal range 1..2^CNT_W-1.
REQ-004 Parameter CH_IS_OUT, default 3'b100: per channel, 1 = output stream (stall = tvalid & ~tready), 0 = input stream (stall = tready & ~tvalid).
REQ-005 clock  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 enable  input  1  detection enable; 0 forces all channels to IDLE.
REQ-008 clear  input  1  single-cycle pulse clearing the sticky first-block record.
REQ-009 tvalid  input  NUM_CH  per-channel AXI-Stream TVALID, observed only.
REQ-010 tready  input  NUM_CH  per-channel AXI-Stream TREADY, observed only.
REQ-011 axis_block_sigs  output  NUM_CH  per-channel registered block flag; drives the deadlock monitor's axis_block_sigs.
REQ-012 first_block_valid  output  1  sticky: some channel has blocked since the last clear/reset.
REQ-013 first_block_ch  output  clog2(NUM_CH)  index of the first channel that blocked.
REQ-014 max_stall  output  CNT_W  largest stall count seen on any channel since the last clear/reset, saturating.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, COUNTING, BLOCKED.
REQ-016 IDLE -> COUNTING when enable=1 and the channel's stall condition is true; counter loads 1.
REQ-017 COUNTING: counter increments by 1 per stalled cycle; when the counter reaches STALL_THRESHOLD, the state SHALL become BLOCKED in the same cycle.
REQ-018 COUNTING or BLOCKED -> IDLE in the cycle after the stall condition is false (handshake tvalid&tready, or both low); counter resets to 0.
REQ-019 BLOCKED: counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 axis_block_sigs[i] SHALL be 1 exactly while channel i is in BLOCKED. With STALL_THRESHOLD=N, the flag rises at the rising edge ending the N-th consecutive stalled cycle, so it is visible in the (N+1)-th cycle.
REQ-021 axis_block_sigs[i] SHALL fall on the first rising edge at which the stall condition is sampled false.
REQ-022 enable=0 SHALL force all channels to IDLE and counters to 0 on the next edge; the sticky record and max_stall are retained.
REQ-023 On the first transition of any channel into BLOCKED while first_block_valid=0: first_block_valid<=1 and first_block_ch<=that index. If several channels enter BLOCKED in the same cycle, the lowest index wins.
REQ-024 first_block_valid/first_block_ch SHALL hold until clear or reset. If clear coincides with a new block entry, clear wins and the new entry is not recorded; a later entry re-arms the record.
REQ-025 max_stall SHALL update to max(max_stall, any channel counter) each cycle. clear zeroes it; clear wins over a same-cycle update.
REQ-026 The block SHALL never drive or modify tvalid/tready; it is a passive observer.

Reset
REQ-027 On reset: all FSMs IDLE, counters 0, axis_block_sigs=0, first_block_valid=0, first_block_ch=0, max_stall=0.
REQ-028 Reset mid-stall SHALL discard partial counts. Counting restarts from 1 on the first stalled cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE=2'd0, COUNTING=2'd1, BLOCKED=2'd2) and the default CNT_W/STALL_THRESHOLD constants.
REQ-030 The per-channel FSM and counter SHALL be one sub-module, mux_1_2_hls_deadlock_stall_chan, instantiated NUM_CH times via generate. Sticky record and max_stall logic stay in the top.

Verification (STALL_THRESHOLD=4, NUM_CH=3, CH_IS_OUT=3'b100)
REQ-031 ch2 tvalid=1, tready=0 held 4 cycles -> axis_block_sigs=3'b100 from cycle 5; first_block_valid=1, first_block_ch=2.
REQ-032 ch0 tready=1, tvalid=0 held 3 cycles then tvalid=1 -> axis_block_sigs[0] stays 0; max_stall=3.
REQ-033 ch0 and ch1 stall starting the same cycle for 6 cycles -> both flags rise together; first_block_ch=0.
REQ-034 ch2 blocked, then tready=1 for one cycle -> flag drops the next edge; re-stall needs 4 new cycles to re-assert.
REQ-035 ch1 stalled 2 cycles, reset pulse, stall continues -> flag rises only after 4 stalled cycles post-reset.
REQ-036 CNT_W=3, ch2 stalled 20 cycles -> counter and max_stall saturate at 7, flag stays 1; clear -> first_block_valid=0, max_stall=0, then max_stall=7 again the next cycle.

Source files
------------

// File: rtl/mux_1_2_hls_deadlock_axis_stall_detector_pkg.sv
// Shared definitions for the AXI-Stream stall detector.
// Holds the per-channel FSM state encoding, default counter sizing and a small
// helper that sizes channel-index fields.
package mux_1_2_hls_deadlock_axis_stall_detector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    BLOCKED  = 2'd2
  } chan_state_e;

  localparam int DEF_CNT_W           = 16;
  localparam int DEF_STALL_THRESHOLD = 16;

  // Width of a field able to hold a channel index; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_1_2_hls_deadlock_stall_chan.sv
// One monitored AXI-Stream channel: stall classification, IDLE/COUNTING/BLOCKED
// FSM and saturating stall counter.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   enable         - 0 forces the channel back to IDLE with a zero count
//   tvalid, tready - observed handshake pair of this channel
//   block          - 1 while the channel is in BLOCKED (state is registered)
//   enter          - 1 in the cycle whose closing edge moves the FSM into BLOCKED
//   count          - current consecutive-stall count (registered)
module mux_1_2_hls_deadlock_stall_chan
  import mux_1_2_hls_deadlock_axis_stall_detector_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int STALL_THRESHOLD = DEF_STALL_THRESHOLD,
  parameter bit IS_OUT          = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tvalid,
  input  logic             tready,
  output logic             block,
  output logic             enter,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STALL_THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  chan_state_e      state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             stall;

  // An output stream stalls when the sink holds off valid data; an input
  // stream stalls when this block is ready but the source has nothing.
  assign stall = IS_OUT ? (tvalid & ~tready) : (tready & ~tvalid);

  always_comb begin
    state_nxt = IDLE;
    count_nxt = '0;
    if (enable && stall) begin
      count_nxt = (state == IDLE) ? CNT_W'(1) : sat_inc(count);
      // Compare the incremented value so the flag rises on the edge that
      // ends the threshold-th stalled cycle.
      state_nxt = (state == BLOCKED || count_nxt == THRESH) ? BLOCKED : COUNTING;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  assign block = (state == BLOCKED);
  assign enter = (state_nxt == BLOCKED) && (state != BLOCKED);

endmodule

// File: rtl/mux_1_2_hls_deadlock_axis_stall_detector.sv
// Passive AXI-Stream stall detector feeding an HLS deadlock monitor.
// Each channel counts consecutive stalled cycles and is flagged once the count
// reaches STALL_THRESHOLD. A sticky record keeps the first channel to block, and
// max_stall tracks the largest stall count seen since the last clear/reset.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   enable            - 0 returns every channel to IDLE (record/max kept)
//   clear             - pulse clearing the first-block record and max_stall
//   tvalid, tready    - per-channel handshake, observed only
//   axis_block_sigs   - per-channel registered block flag
//   first_block_valid - some channel has blocked since last clear/reset
//   first_block_ch    - index of that first channel
//   max_stall         - saturating maximum stall count
module mux_1_2_hls_deadlock_axis_stall_detector
  import mux_1_2_hls_deadlock_axis_stall_detector_pkg::*;
#(
  parameter int                NUM_CH          = 3,
  parameter int                CNT_W           = DEF_CNT_W,
  parameter int                STALL_THRESHOLD = DEF_STALL_THRESHOLD,
  parameter logic [NUM_CH-1:0] CH_IS_OUT       = 3'b100,
  localparam int               CH_W            = idx_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              first_block_valid,
  output logic [CH_W-1:0]   first_block_ch,
  output logic [CNT_W-1:0]  max_stall
);

  logic [NUM_CH-1:0]            enter;
  logic [NUM_CH-1:0][CNT_W-1:0] chan_cnt;
  logic                         enter_any;
  logic [CH_W-1:0]              enter_idx;
  logic [CNT_W-1:0]             max_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    mux_1_2_hls_deadlock_stall_chan #(
      .CNT_W          (CNT_W),
      .STALL_THRESHOLD(STALL_THRESHOLD),
      .IS_OUT         (CH_IS_OUT[g])
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .tvalid(tvalid[g]),
      .tready(tready[g]),
      .block (axis_block_sigs[g]),
      .enter (enter[g]),
      .count (chan_cnt[g])
    );
  end

  // Descending scan so the lowest simultaneously-entering index is kept.
  always_comb begin
    enter_any = 1'b0;
    enter_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) begin
        enter_any = 1'b1;
        enter_idx = CH_W'(i);
      end
    end
  end

  always_comb begin
    max_nxt = max_stall;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_cnt[i] > max_nxt) max_nxt = chan_cnt[i];
    end
  end

  // clear takes priority over both a new block entry and a max update.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      first_block_valid <= 1'b0;
      first_block_ch    <= '0;
      max_stall         <= '0;
    end else begin
      if (!first_block_valid && enter_any) begin
        first_block_valid <= 1'b1;
        first_block_ch    <= enter_idx;
      end
      max_stall <= max_nxt;
    end
  end

endmodule

// File: tb/tb_mux_1_2_hls_deadlock_axis_stall_detector.sv
// Self-checking bench for mux_1_2_hls_deadlock_axis_stall_detector with
// NUM_CH=3, STALL_THRESHOLD=4, CH_IS_OUT=3'b100, CNT_W=3 (so saturation at 7
// is reachable). Each cycle a reference model pushes the expected outputs into
// a queue; after the clock edge the entry is popped and compared. Directed
// checks with hand-derived values cover the named scenarios.
module tb_mux_1_2_hls_deadlock_axis_stall_detector;

  localparam int         THR     = 4;
  localparam int         CMAX    = 7;
  localparam logic [2:0] CH_OUT  = 3'b100;

  logic       clock = 1'b0;
  logic       reset, enable, clear;
  logic [2:0] tvalid, tready;
  logic [2:0] axis_block_sigs;
  logic       first_block_valid;
  logic [1:0] first_block_ch;
  logic [2:0] max_stall;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] blk;
    logic       fv;
    logic [1:0] fch;
    logic [2:0] mx;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int m_cnt[3];
  bit m_blk[3];
  bit m_fv;
  int m_fch;
  int m_max;

  mux_1_2_hls_deadlock_axis_stall_detector #(
    .NUM_CH         (3),
    .CNT_W          (3),
    .STALL_THRESHOLD(THR),
    .CH_IS_OUT      (CH_OUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .clear            (clear),
    .tvalid           (tvalid),
    .tready           (tready),
    .axis_block_sigs  (axis_block_sigs),
    .first_block_valid(first_block_valid),
    .first_block_ch   (first_block_ch),
    .max_stall        (max_stall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic [2:0] tv, input logic [2:0] tr,
                     input logic en, input logic clr, input logic rst);
    int   n_cnt[3];
    bit   n_blk[3];
    int   n_max;
    int   ent_ch;
    bit   st;
    exp_t e;
    exp_t got;

    @(negedge clock);
    tvalid = tv;
    tready = tr;
    enable = en;
    clear  = clr;
    reset  = rst;

    n_max  = m_max;
    ent_ch = -1;
    for (int i = 0; i < 3; i++) begin
      if (m_cnt[i] > n_max) n_max = m_cnt[i];
      st = CH_OUT[i] ? (tv[i] && !tr[i]) : (tr[i] && !tv[i]);
      if (en && st) n_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      else          n_cnt[i] = 0;
      n_blk[i] = (n_cnt[i] >= THR);
      if (n_blk[i] && !m_blk[i] && ent_ch < 0) ent_ch = i;
    end

    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        n_cnt[i] = 0;
        n_blk[i] = 1'b0;
      end
      m_fv = 1'b0; m_fch = 0; m_max = 0;
    end else if (clr) begin
      m_fv = 1'b0; m_fch = 0; m_max = 0;
    end else begin
      if (!m_fv && ent_ch >= 0) begin
        m_fv  = 1'b1;
        m_fch = ent_ch;
      end
      m_max = n_max;
    end
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = n_cnt[i];
      m_blk[i] = n_blk[i];
      e.blk[i] = n_blk[i];
    end
    e.fv  = m_fv;
    e.fch = 2'(m_fch);
    e.mx  = 3'(m_max);
    q.push_back(e);

    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      got = q.pop_front();
      check("sb_block", axis_block_sigs, got.blk);
      check("sb_fvalid", first_block_valid, got.fv);
      check("sb_fch", first_block_ch, got.fch);
      check("sb_max", max_stall, got.mx);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; tvalid = '0; tready = '0;
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_blk[i] = 1'b0; end
    m_fv = 1'b0; m_fch = 0; m_max = 0;

    // Reset state
    cyc(3'b000, 3'b000, 1, 0, 1);
    cyc(3'b000, 3'b000, 1, 0, 1);
    check("rst_block", axis_block_sigs, 3'b000);
    check("rst_fvalid", first_block_valid, 1'b0);
    check("rst_fch", first_block_ch, 2'd0);
    check("rst_max", max_stall, 3'd0);

    // Output channel 2 stalls for 4 cycles
    repeat (3) cyc(3'b100, 3'b000, 1, 0, 0);
    check("ch2_before_thr", axis_block_sigs, 3'b000);
    cyc(3'b100, 3'b000, 1, 0, 0);
    check("ch2_block", axis_block_sigs, 3'b100);
    check("ch2_fvalid", first_block_valid, 1'b1);
    check("ch2_fch", first_block_ch, 2'd2);
    cyc(3'b000, 3'b000, 1, 0, 0);
    check("ch2_release", axis_block_sigs, 3'b000);
    cyc(3'b000, 3'b000, 1, 1, 0);
    check("clear_fvalid", first_block_valid, 1'b0);
    check("clear_max", max_stall, 3'd0);

    // Input channel 0 starved 3 cycles then handshakes
    repeat (3) cyc(3'b000, 3'b001, 1, 0, 0);
    cyc(3'b001, 3'b001, 1, 0, 0);
    check("ch0_noblock", axis_block_sigs, 3'b000);
    check("ch0_max3", max_stall, 3'd3);
    cyc(3'b000, 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0);

    // Channels 0 and 1 stall together
    repeat (3) cyc(3'b000, 3'b011, 1, 0, 0);
    check("dual_before", axis_block_sigs, 3'b000);
    cyc(3'b000, 3'b011, 1, 0, 0);
    check("dual_block", axis_block_sigs, 3'b011);
    check("dual_fch", first_block_ch, 2'd0);
    repeat (2) cyc(3'b000, 3'b011, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0);

    // Blocked channel drops on a handshake and needs a full re-count
    repeat (5) cyc(3'b100, 3'b000, 1, 0, 0);
    check("rb_block", axis_block_sigs, 3'b100);
    cyc(3'b100, 3'b100, 1, 0, 0);
    check("rb_drop", axis_block_sigs, 3'b000);
    repeat (3) cyc(3'b100, 3'b000, 1, 0, 0);
    check("rb_recount", axis_block_sigs, 3'b000);
    cyc(3'b100, 3'b000, 1, 0, 0);
    check("rb_reassert", axis_block_sigs, 3'b100);
    cyc(3'b000, 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0);

    // Reset in the middle of a channel-1 stall
    repeat (2) cyc(3'b000, 3'b010, 1, 0, 0);
    cyc(3'b000, 3'b010, 1, 0, 1);
    check("mid_rst_max", max_stall, 3'd0);
    repeat (3) cyc(3'b000, 3'b010, 1, 0, 0);
    check("post_rst_before", axis_block_sigs, 3'b000);
    cyc(3'b000, 3'b010, 1, 0, 0);
    check("post_rst_block", axis_block_sigs, 3'b010);
    check("post_rst_fch", first_block_ch, 2'd1);
    cyc(3'b000, 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0);

    // Long stall: counter saturates, clear then max recovers
    repeat (20) cyc(3'b100, 3'b000, 1, 0, 0);
    check("sat_block", axis_block_sigs, 3'b100);
    check("sat_max", max_stall, 3'd7);
    cyc(3'b100, 3'b000, 1, 1, 0);
    check("sat_clr_fvalid", first_block_valid, 1'b0);
    check("sat_clr_max", max_stall, 3'd0);
    check("sat_clr_block", axis_block_sigs, 3'b100);
    cyc(3'b100, 3'b000, 1, 0, 0);
    check("sat_max_again", max_stall, 3'd7);

    // Disable forces IDLE but keeps max_stall
    cyc(3'b100, 3'b000, 0, 0, 0);
    check("dis_block", axis_block_sigs, 3'b000);
    check("dis_max", max_stall, 3'd7);
    cyc(3'b000, 3'b000, 1, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0);

    // clear coinciding with an entry wins; a later entry re-arms the record
    repeat (3) cyc(3'b000, 3'b001, 1, 0, 0);
    cyc(3'b000, 3'b001, 1, 1, 0);
    check("clrwin_block", axis_block_sigs, 3'b001);
    check("clrwin_fvalid", first_block_valid, 1'b0);
    repeat (4) cyc(3'b000, 3'b011, 1, 0, 0);
    check("rearm_fvalid", first_block_valid, 1'b1);
    check("rearm_fch", first_block_ch, 2'd1);

    check("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
